// File: rtl/ntt_out_buffer_if.sv
// Write-pair bus from the reorder address generator, natural-order output stream and
// status flags of the NTT output buffer.
interface ntt_out_buffer_if #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  wr_en;
  logic [NUM_STAGES-1:0] wr_addr_top;
  logic [NUM_STAGES-1:0] wr_addr_bot;
  logic [DATA_WIDTH-1:0] wr_data_top;
  logic [DATA_WIDTH-1:0] wr_data_bot;
  logic                  out_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [NUM_STAGES-1:0] out_index;
  logic                  out_last;
  logic                  fill_done;
  logic                  done;
  logic                  err;

  modport master (
    output wr_en, wr_addr_top, wr_addr_bot, wr_data_top, wr_data_bot, out_ready,
    input  out_valid, out_data, out_index, out_last, fill_done, done, err
  );

  modport slave (
    input  wr_en, wr_addr_top, wr_addr_bot, wr_data_top, wr_data_bot, out_ready,
    output out_valid, out_data, out_index, out_last, fill_done, done, err
  );
endinterface

// File: rtl/ntt_out_buffer.sv
// NTT output buffer: captures N/2 butterfly pairs at scattered addresses, then drains the
// N coefficients in natural order over valid/ready with zero-bubble backpressure.
module ntt_out_buffer #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input logic             clk,
  input logic             reset,
  ntt_out_buffer_if.slave bus
);
  localparam int unsigned N = 1 << NUM_STAGES;
  localparam logic [NUM_STAGES:0]   PtrOne = (NUM_STAGES + 1)'(1);
  localparam logic [NUM_STAGES-2:0] CntOne = (NUM_STAGES - 1)'(1);

  typedef enum logic [1:0] {StFill, StDrain, StDone} state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   mem_q [N];
  logic [N-1:0]            map_q;
  logic [NUM_STAGES-2:0]   pair_cnt_q;
  // Extra MSB marks that the pointer has moved past N-1.
  logic [NUM_STAGES:0]     rd_ptr_q;
  logic                    out_valid_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [NUM_STAGES-1:0]   out_index_q;
  logic                    out_last_q;
  logic                    fill_done_q;
  logic                    done_q;
  logic                    err_q;

  logic fill_wr;
  logic accept_last;
  logic load;

  assign fill_wr     = (state_q == StFill) && bus.wr_en;
  assign accept_last = out_valid_q && bus.out_ready && out_last_q;
  assign load        = (!out_valid_q || bus.out_ready) && !rd_ptr_q[NUM_STAGES];

  // Array has no reset; bottom write is issued last so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (!reset && fill_wr) begin
      mem_q[bus.wr_addr_top] <= bus.wr_data_top;
      mem_q[bus.wr_addr_bot] <= bus.wr_data_bot;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFill;
      map_q       <= '0;
      pair_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      fill_done_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (bus.wr_en && state_q != StFill) err_q <= 1'b1;
      case (state_q)
        StFill: begin
          if (bus.wr_en) begin
            map_q[bus.wr_addr_top] <= 1'b1;
            map_q[bus.wr_addr_bot] <= 1'b1;
            pair_cnt_q             <= pair_cnt_q + CntOne;
            if (bus.wr_addr_top == bus.wr_addr_bot ||
                map_q[bus.wr_addr_top] || map_q[bus.wr_addr_bot]) begin
              err_q <= 1'b1;
            end
            // fill_done doubles as the counter's terminal flag.
            if (pair_cnt_q == '1) begin
              state_q     <= StDrain;
              fill_done_q <= 1'b1;
            end
          end
        end
        StDrain: begin
          if (accept_last) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= StDone;
          end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mem_q[rd_ptr_q[NUM_STAGES-1:0]];
            out_index_q <= rd_ptr_q[NUM_STAGES-1:0];
            out_last_q  <= (rd_ptr_q[NUM_STAGES-1:0] == '1);
            rd_ptr_q    <= rd_ptr_q + PtrOne;
          end
        end
        StDone: ;
        default: state_q <= StFill;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;
  assign bus.out_last  = out_last_q;
  assign bus.fill_done = fill_done_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_ntt_out_buffer.sv
// Directed bench for ntt_out_buffer (N=16, 16-bit data): fill, drain, backpressure,
// duplicate/collision/late-write errors and mid-drain reset.
module tb_ntt_out_buffer;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   exp_mem [16];

  ntt_out_buffer_if #(.NUM_STAGES(4), .DATA_WIDTH(16)) bus ();

  ntt_out_buffer #(.NUM_STAGES(4), .DATA_WIDTH(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] top_of(input int c);
    logic [2:0] cb;
    cb = 3'(c);
    return {1'b0, ~cb[0], cb[2], cb[1]};
  endfunction

  task automatic put_pair(input logic [3:0] at, input logic [3:0] ab,
                          input logic [15:0] dt, input logic [15:0] db);
    bus.wr_en       = 1'b1;
    bus.wr_addr_top = at;
    bus.wr_addr_bot = ab;
    bus.wr_data_top = dt;
    bus.wr_data_bot = db;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic put_std(input int c, input int off);
    logic [3:0] t;
    t = top_of(c);
    put_pair(t, t | 4'h8, 16'(3 * t + off), 16'(3 * (t | 4'h8) + off));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Standard 8-pair fill; data = 3*addr + off.
  task automatic fill_std(input int off);
    for (int i = 0; i < 16; i++) exp_mem[i] = 3 * i + off;
    for (int c = 0; c < 8; c++) begin
      put_std(c, off);
      if (c < 7) check("fill_done_early", 32'(bus.fill_done), 0);
    end
    check("fill_done", 32'(bus.fill_done), 1);
    check("valid_before_drain", 32'(bus.out_valid), 0);
  endtask

  // Drain with out_ready held high; optionally inject a late write at word inject_at.
  task automatic drain_full(input int inject_at);
    bus.out_ready = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", 32'(bus.out_valid), 1);
      check("drain_index", 32'(bus.out_index), 32'(i));
      check("drain_data", 32'(bus.out_data), 32'(exp_mem[i]));
      check("drain_last", 32'(bus.out_last), 32'(i == 15));
      if (i == inject_at) begin
        bus.wr_en       = 1'b1;
        bus.wr_addr_top = 4'd10;
        bus.wr_addr_bot = 4'd11;
        bus.wr_data_top = 16'hFFFF;
        bus.wr_data_bot = 16'hFFFF;
      end
      step();
      bus.wr_en = 1'b0;
    end
    check("done_after_drain", 32'(bus.done), 1);
    check("valid_after_drain", 32'(bus.out_valid), 0);
  endtask

  initial begin
    logic [5:0]  pat;
    int          exp_idx;
    logic        hold;
    logic [15:0] prev_data;

    n_tests = 0;
    n_fail  = 0;
    reset         = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr_top = '0;
    bus.wr_addr_bot = '0;
    bus.wr_data_top = '0;
    bus.wr_data_bot = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_data", 32'(bus.out_data), 0);
    check("rst_index", 32'(bus.out_index), 0);
    check("rst_last", 32'(bus.out_last), 0);
    check("rst_fill_done", 32'(bus.fill_done), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err", 32'(bus.err), 0);

    // 1: plain fill and full-rate drain
    fill_std(0);
    drain_full(-1);
    check("t1_err", 32'(bus.err), 0);

    // 2: backpressure pattern 1,0,0,1,0,1 repeating
    do_reset();
    fill_std(0);
    pat       = 6'b101001;
    exp_idx   = 0;
    hold      = 1'b0;
    prev_data = '0;
    for (int cyc = 0; cyc < 100 && exp_idx < 16; cyc++) begin
      bus.out_ready = pat[cyc % 6];
      if (bus.out_valid) begin
        check("bp_index", 32'(bus.out_index), 32'(exp_idx));
        check("bp_data", 32'(bus.out_data), 32'(3 * exp_idx));
        if (hold) check("bp_stable", 32'(bus.out_data), 32'(prev_data));
      end
      hold      = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      if (bus.out_valid && bus.out_ready) exp_idx++;
      step();
    end
    check("bp_count", 32'(exp_idx), 16);
    check("bp_done", 32'(bus.done), 1);
    check("bp_err", 32'(bus.err), 0);

    // 3: third pair repeats the second pair's addresses
    do_reset();
    for (int i = 0; i < 16; i++) exp_mem[i] = 3 * i;
    exp_mem[0] = 16'h1111;
    exp_mem[8] = 16'h2222;
    put_std(0, 0);
    put_std(1, 0);
    check("dup_err_before", 32'(bus.err), 0);
    put_pair(4'd0, 4'd8, 16'h1111, 16'h2222);
    check("dup_err", 32'(bus.err), 1);
    for (int c = 3; c < 8; c++) begin
      check("dup_fill_early", 32'(bus.fill_done), 0);
      put_std(c, 0);
    end
    check("dup_fill_done", 32'(bus.fill_done), 1);
    drain_full(-1);
    check("dup_err_sticky", 32'(bus.err), 1);

    // 4: top and bottom address collide at 5
    do_reset();
    check("col_err_cleared", 32'(bus.err), 0);
    for (int i = 0; i < 16; i++) exp_mem[i] = 3 * i;
    exp_mem[5] = 16'h5555;
    put_std(0, 0);
    put_std(1, 0);
    put_pair(4'd5, 4'd5, 16'hAAAA, 16'h5555);
    check("col_err", 32'(bus.err), 1);
    for (int c = 3; c < 8; c++) put_std(c, 0);
    check("col_fill_done", 32'(bus.fill_done), 1);
    drain_full(-1);

    // 5: write pulse during drain is ignored but flagged
    do_reset();
    fill_std(0);
    check("late_err_before", 32'(bus.err), 0);
    drain_full(3);
    check("late_err", 32'(bus.err), 1);

    // 6: reset mid-drain at index 7, then a fresh fill
    do_reset();
    fill_std(0);
    bus.out_ready = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      check("mid_index", 32'(bus.out_index), 32'(i));
      step();
    end
    check("mid_at7", 32'(bus.out_index), 7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_valid", 32'(bus.out_valid), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    check("mid_rst_fill", 32'(bus.fill_done), 0);
    bus.out_ready = 1'b0;
    fill_std(1);
    drain_full(-1);
    check("mid_err", 32'(bus.err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
